alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter FP_LATENCY, default 3, legal range 1..15: number of EXEC cycles an FP op is held on the ALU before its result is sampled.
REQ-002 SHALL have parameter INT_LATENCY, default 1, legal range 1..15: the same for integer ops.
REQ-003 SHALL have ports, in order:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  stage can accept an op.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- in_op  input  3  ALU opcode.
- in_is_fp  input  1  FP op select.
- in_rd  input  5  destination register tag.
- alu_a  output  32  operand A to ALU.
- alu_b  output  32  operand B to ALU.
- alu_op  output  3  opcode to ALU.
- alu_is_fp  output  1  FP select to ALU.
- alu_result  input  32  combinational ALU result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  32  registered result.
- out_rd  output  5  tag of out_result.
- out_is_fp  output  1  FP flag of out_result.
- busy  output  1  high unless in IDLE with the queue empty.

Function
REQ-004 SHALL contain a 2-entry FIFO queue of {a, b, op, is_fp, rd}; a push occurs on a rising edge with in_valid && in_ready.
REQ-005 SHALL drive in_ready = (queue count < 2), registered-state only; it SHALL NOT depend combinationally on out_ready or in_valid.
REQ-006 SHALL have an FSM with states IDLE, EXEC, DONE.
REQ-007 IDLE: if the queue is non-empty, SHALL pop the head into the operand register, load cnt = latency-1 (per is_fp), and go to EXEC.
REQ-008 EXEC: SHALL drive alu_* from the operand register; if cnt != 0, SHALL decrement; if cnt == 0, SHALL capture alu_result, rd and is_fp into the out_* registers, set out_valid, and go to DONE.
REQ-009 DONE: SHALL hold out_* stable while out_valid && !out_ready; on out_ready it SHALL clear out_valid and either pop the next head directly into EXEC (queue non-empty) or go to IDLE.
REQ-010 alu_a, alu_b, alu_op and alu_is_fp SHALL be 0 in IDLE and DONE.
REQ-011 Latency: an op pushed into an empty, IDLE stage at edge T SHALL raise out_valid after edge T+1+L, where L is INT_LATENCY or FP_LATENCY.
REQ-012 A push and a pop on the same edge SHALL both take effect, leaving count unchanged; a push while full is impossible because in_ready = 0.
REQ-013 Ops SHALL complete strictly in push order; no op SHALL be dropped or duplicated.
REQ-014 Queue pointers SHALL be 1 bit and wrap modulo 2; count SHALL be 2 bits, range 0..2.

Reset
REQ-015 While rst_n = 0, SHALL immediately force state IDLE, count 0, pointers 0, cnt 0, out_valid 0, out_result 0, out_rd 0, out_is_fp 0, alu_* 0, in_ready 1, busy 0.
REQ-016 Reset asserted mid-EXEC or mid-DONE SHALL discard all queued and in-flight ops; no result for them SHALL appear after release.
REQ-017 First push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (bench instantiates the team's alu on the alu_* ports)
REQ-018 Int ADD: a=10, b=5, op=000, is_fp=0, pushed at edge T -> out_valid after edge T+2, out_result=15, out_rd matches.
REQ-019 FP ADD: a=0x3f800000, b=0x40000000, op=000, is_fp=1, FP_LATENCY=3 -> out_valid after edge T+4, out_result=0x40400000, out_is_fp=1.
REQ-020 Back-to-back: SUB (20-7), then FP MUL (0x3f800000 * 0x40000000), then ADD pushed on consecutive edges, out_ready=1 -> in_ready drops to 0 when the queue is full; results 13, 0x40000000, then the ADD result appear in order.
REQ-021 Backpressure: out_ready=0 for 5 cycles with a result pending -> out_result, out_rd and out_valid hold; the queue fills to 2; once out_ready=1, the remaining ops drain in order.
REQ-022 Reset mid-op: assert rst_n=0 during EXEC of an FP op with 1 op queued -> all outputs per REQ-015 immediately; no out_valid after release until a new push.
REQ-023 Simultaneous push and pop at count=1 -> count stays 1, and both ops complete in order.

Source files
------------

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: 2-entry op queue, fixed-latency EXEC hold, registered result
module alu_issue_stage #(
  parameter int unsigned FP_LATENCY  = 3,
  parameter int unsigned INT_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  input  logic        in_is_fp,
  input  logic [4:0]  in_rd,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_is_fp,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_is_fp,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        is_fp;
    logic [4:0]  rd;
  } entry_t;

  // Countdown preloads: the op spends exactly LATENCY cycles in EXEC.
  localparam logic [3:0] FP_CNT  = 4'(FP_LATENCY - 1);
  localparam logic [3:0] INT_CNT = 4'(INT_LATENCY - 1);

  entry_t      q_mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;

  state_e      state_q, state_d;
  entry_t      op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_is_fp_q, out_is_fp_d;

  logic        push, pop;
  entry_t      head, in_entry;

  // in_ready comes purely from the registered occupancy, never from out_ready.
  assign in_ready = (count_q != 2'd2);
  assign push     = in_valid && in_ready;
  assign head     = q_mem_q[rd_ptr_q];
  assign in_entry = '{a: in_a, b: in_b, op: in_op, is_fp: in_is_fp, rd: in_rd};

  // Queue storage and pointers; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_mem_q[0] <= '0;
      q_mem_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      if (push) begin
        q_mem_q[wr_ptr_q] <= in_entry;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FSM, operand register, countdown and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      cnt_q        <= 4'd0;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
      out_rd_q     <= 5'd0;
      out_is_fp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_is_fp_q  <= out_is_fp_d;
    end
  end

  // Next-state logic: pop into EXEC, count down, capture, then hand off downstream.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_is_fp_d  = out_is_fp_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          op_d    = head;
          cnt_d   = head.is_fp ? FP_CNT : INT_CNT;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_result_d = alu_result;
          out_rd_d     = op_q.rd;
          out_is_fp_d  = op_q.is_fp;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (count_q != 2'd0) begin
            // Skip IDLE so back-to-back ops lose no cycle.
            pop     = 1'b1;
            op_d    = head;
            cnt_d   = head.is_fp ? FP_CNT : INT_CNT;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ALU operands are only presented while an op is executing.
  always_comb begin
    alu_a     = 32'd0;
    alu_b     = 32'd0;
    alu_op    = 3'd0;
    alu_is_fp = 1'b0;
    if (state_q == EXEC) begin
      alu_a     = op_q.a;
      alu_b     = op_q.b;
      alu_op    = op_q.op;
      alu_is_fp = op_q.is_fp;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;
  assign out_is_fp  = out_is_fp_q;
  assign busy       = !((state_q == IDLE) && (count_q == 2'd0));

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0]  in_op = '0;
  logic        in_is_fp = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_is_fp;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_is_fp;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        fp;
  } res_t;
  res_t results[$];

  alu_issue_stage #(.FP_LATENCY(3), .INT_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_is_fp(in_is_fp), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_is_fp(alu_is_fp),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_is_fp(out_is_fp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: single precision routed through double precision reals.
  function automatic logic [63:0] sp2dp(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:0] == 31'd0) return {s[31], 63'd0};
    e = {3'b000, s[30:23]} + 11'd896;
    return {s[31], e, s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    logic [10:0] e;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  real ra, rb, rr;
  always_comb begin
    ra = $bitstoreal(sp2dp(alu_a));
    rb = $bitstoreal(sp2dp(alu_b));
    rr = 0.0;
    alu_result = 32'd0;
    if (alu_is_fp) begin
      case (alu_op)
        3'd0:    rr = ra + rb;
        3'd1:    rr = ra - rb;
        3'd2:    rr = ra * rb;
        default: rr = 0.0;
      endcase
      alu_result = dp2sp($realtobits(rr));
    end else begin
      case (alu_op)
        3'd0:    alu_result = alu_a + alu_b;
        3'd1:    alu_result = alu_a - alu_b;
        3'd2:    alu_result = alu_a * alu_b;
        3'd3:    alu_result = alu_a & alu_b;
        3'd4:    alu_result = alu_a | alu_b;
        3'd5:    alu_result = alu_a ^ alu_b;
        default: alu_result = 32'd0;
      endcase
    end
  end

  // Record each result handshake that the next rising edge will complete.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) results.push_back({out_result, out_rd, out_is_fp});
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic fp, input logic [4:0] rd);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL push_wait: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_is_fp = fp; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int c;
    c = 0;
    while (results.size() < n && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (results.size() < n) begin
      fails++;
      $display("FAIL wait_results: got %0d results, required %0d", results.size(), n);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({out_valid, out_result, out_rd, out_is_fp, alu_a, alu_b, alu_op, alu_is_fp, in_ready, busy}
        !== {1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: ov=%b res=%h rd=%h fp=%b a=%h b=%h op=%h afp=%b rdy=%b busy=%b required 0,0,0,0,0,0,0,0,1,0",
               out_valid, out_result, out_rd, out_is_fp, alu_a, alu_b, alu_op, alu_is_fp, in_ready, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(32'd2, 32'd3, 3'd0, 1'b0, 5'd3);
    wait_results(1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (results.size() < 1 || results[0] !== {32'd5, 5'd3, 1'b0}) begin
      fails++;
      $display("FAIL first_push_after_reset: got %h required %h",
               (results.size() > 0) ? results[0] : '0, {32'd5, 5'd3, 1'b0});
    end
    results.delete();
  endtask

  task automatic test_int_add;
    push(32'd10, 32'd5, 3'd0, 1'b0, 5'd17);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL int_t0: out_valid=%b busy=%b required 0,1", out_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || alu_a !== 32'd10 || alu_b !== 32'd5 || alu_is_fp !== 1'b0) begin
      fails++;
      $display("FAIL int_t1: out_valid=%b alu_a=%h alu_b=%h fp=%b required 0,a,5,0", out_valid, alu_a, alu_b, alu_is_fp);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd15 || out_rd !== 5'd17 || out_is_fp !== 1'b0 || alu_a !== 32'd0) begin
      fails++;
      $display("FAIL int_t2: ov=%b res=%h rd=%h fp=%b alu_a=%h required 1,f,11,0,0",
               out_valid, out_result, out_rd, out_is_fp, alu_a);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL int_drain: out_valid=%b busy=%b required 0,0", out_valid, busy);
    end
    results.delete();
  endtask

  task automatic test_fp_add;
    push(32'h3f800000, 32'h40000000, 3'd0, 1'b1, 5'd4);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || alu_is_fp !== 1'b1) begin
        fails++;
        $display("FAIL fp_wait_%0d: out_valid=%b alu_is_fp=%b required 0,1", i, out_valid, alu_is_fp);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h40400000 || out_is_fp !== 1'b1 || out_rd !== 5'd4) begin
      fails++;
      $display("FAIL fp_t4: ov=%b res=%h fp=%b rd=%h required 1,40400000,1,4", out_valid, out_result, out_is_fp, out_rd);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    results.delete();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    push(32'd20, 32'd7, 3'd1, 1'b0, 5'd1);
    push(32'h3f800000, 32'h40000000, 3'd2, 1'b1, 5'd2);
    push(32'd3, 32'd4, 3'd0, 1'b0, 5'd3);
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_full: in_ready=%b required 0", in_ready);
    end
    wait_results(3);
    checks++;
    if (results.size() != 3 || results[0] !== {32'd13, 5'd1, 1'b0} ||
        results[1] !== {32'h40000000, 5'd2, 1'b1} || results[2] !== {32'd7, 5'd3, 1'b0}) begin
      fails++;
      $display("FAIL b2b_order: n=%0d got %h %h %h required %h %h %h", results.size(),
               (results.size() > 0) ? results[0] : '0, (results.size() > 1) ? results[1] : '0,
               (results.size() > 2) ? results[2] : '0,
               {32'd13, 5'd1, 1'b0}, {32'h40000000, 5'd2, 1'b1}, {32'd7, 5'd3, 1'b0});
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    results.delete();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    push(32'd100, 32'd1, 3'd1, 1'b0, 5'd10);
    push(32'h0f0f, 32'h00ff, 3'd3, 1'b0, 5'd11);
    push(32'd6, 32'd7, 3'd2, 1'b0, 5'd12);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd99 || out_rd !== 5'd10 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_%0d: ov=%b res=%h rd=%h rdy=%b required 1,63,a,0", i, out_valid, out_result, out_rd, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_results(3);
    checks++;
    if (results.size() != 3 || results[0] !== {32'd99, 5'd10, 1'b0} ||
        results[1] !== {32'h000f, 5'd11, 1'b0} || results[2] !== {32'd42, 5'd12, 1'b0}) begin
      fails++;
      $display("FAIL bp_order: n=%0d got %h %h %h", results.size(),
               (results.size() > 0) ? results[0] : '0, (results.size() > 1) ? results[1] : '0,
               (results.size() > 2) ? results[2] : '0);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    results.delete();
  endtask

  task automatic test_reset_mid_op;
    out_ready = 1'b1;
    push(32'h3f800000, 32'h40000000, 3'd0, 1'b1, 5'd9);
    push(32'd8, 32'd8, 3'd0, 1'b0, 5'd8);
    checks++;
    if (alu_a !== 32'h3f800000 || alu_is_fp !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_exec: alu_a=%h fp=%b ov=%b required 3f800000,1,0", alu_a, alu_is_fp, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_result, out_rd, out_is_fp, alu_a, alu_b, alu_op, alu_is_fp, in_ready, busy}
        !== {1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset_state: ov=%b res=%h rd=%h fp=%b a=%h b=%h op=%h afp=%b rdy=%b busy=%b",
               out_valid, out_result, out_rd, out_is_fp, alu_a, alu_b, alu_op, alu_is_fp, in_ready, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_idle_%0d: out_valid=%b busy=%b required 0,0", i, out_valid, busy);
      end
    end
    out_ready = 1'b0;
    results.delete();
  endtask

  task automatic test_push_pop;
    out_ready = 1'b0;
    push(32'd1, 32'd2, 3'd0, 1'b0, 5'd21);
    push(32'd9, 32'd4, 3'd1, 1'b0, 5'd22);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL pp_pre: out_valid=%b in_ready=%b required 1,1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    push(32'd6, 32'd3, 3'd5, 1'b0, 5'd23);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL pp_count: in_ready=%b required 1", in_ready);
    end
    wait_results(3);
    checks++;
    if (results.size() != 3 || results[0] !== {32'd3, 5'd21, 1'b0} ||
        results[1] !== {32'd5, 5'd22, 1'b0} || results[2] !== {32'd5, 5'd23, 1'b0}) begin
      fails++;
      $display("FAIL pp_order: n=%0d got %h %h %h", results.size(),
               (results.size() > 0) ? results[0] : '0, (results.size() > 1) ? results[1] : '0,
               (results.size() > 2) ? results[2] : '0);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    results.delete();
  endtask

  initial begin
    #2;
    test_reset;
    test_int_add;
    test_fp_add;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_op;
    test_push_pop;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
